gtx_frame_rx: RTL and testbench

GTX_FRAME_RX -- requirements
Module: gtx_frame_rx

---
 rtl/gtx_frame_rx.sv | 249 ++++++++++++++++++++++++
 tb/tb_gtx_frame_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gtx_frame_rx.sv
// GTX 16-bit framed receiver: link lock/unlock tracking on IDLE/illegal words plus SOF/length framing.
// Optional trailing XOR checksum word is enabled by defining GTX_FRAME_RX_CHECKSUM_EN.
module gtx_frame_rx #(
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_CNT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [1:0]  ctrl_i,
    input  logic [15:0] data_i,
    output logic [15:0] data_o,
    output logic        valid_o,
    output logic        sof_o,
    output logic        eof_o,
    output logic        frame_ok_o,
    output logic        frame_err_o,
    output logic        link_up_o,
    output logic [15:0] err_cnt_o
);

    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_CNT - 1);

    typedef enum logic {
        LINK_DOWN = 1'b0,
        LINK_UP   = 1'b1
    } link_state_e;

    typedef enum logic [1:0] {
        FR_IDLE    = 2'd0,
        FR_PAYLOAD = 2'd1,
        FR_CHECK   = 2'd2
    } frame_state_e;

    link_state_e  link_state_q, link_state_d;
    frame_state_e frame_state_q, frame_state_d;

    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic [3:0]  bad_cnt_q, bad_cnt_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] csum_q, csum_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        frame_ok_q, frame_ok_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic word_idle_s;
    logic word_sof_s;
    logic word_data_s;
    logic word_illegal_s;
    logic link_up_s;
    logic link_drop_s;

    // Classify the incoming word.
    always_comb begin
        word_idle_s    = (ctrl_i == 2'b01) && (data_i == 16'h50BC);
        word_sof_s     = (ctrl_i == 2'b01) && (data_i[7:0] == 8'hFB);
        word_data_s    = (ctrl_i == 2'b00);
        word_illegal_s = !(word_idle_s || word_sof_s || word_data_s);
    end

    // Link FSM: count consecutive IDLE words to lock, consecutive illegal words to unlock.
    always_comb begin
        link_state_d = link_state_q;
        lock_cnt_d   = lock_cnt_q;
        bad_cnt_d    = bad_cnt_q;
        case (link_state_q)
            LINK_DOWN: begin
                bad_cnt_d = 4'd0;
                if (word_idle_s) begin
                    if (lock_cnt_q == LOCK_LAST) begin
                        link_state_d = LINK_UP;
                        lock_cnt_d   = 8'd0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 8'd1;
                    end
                end else begin
                    lock_cnt_d = 8'd0;
                end
            end
            LINK_UP: begin
                lock_cnt_d = 8'd0;
                if (word_illegal_s) begin
                    if (bad_cnt_q == UNLOCK_LAST) begin
                        link_state_d = LINK_DOWN;
                        bad_cnt_d    = 4'd0;
                    end else begin
                        bad_cnt_d = bad_cnt_q + 4'd1;
                    end
                end else begin
                    bad_cnt_d = 4'd0;
                end
            end
            default: begin
                link_state_d = LINK_DOWN;
                lock_cnt_d   = 8'd0;
                bad_cnt_d    = 4'd0;
            end
        endcase
    end

    // Link qualifiers used by the frame FSM.
    always_comb begin
        link_up_s   = (link_state_q == LINK_UP);
        link_drop_s = link_up_s && (link_state_d == LINK_DOWN);
    end

    // Frame FSM: payload forwarding, abort handling and optional checksum check.
    always_comb begin
        frame_state_d = frame_state_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        csum_d        = csum_q;
        data_d        = data_q;
        valid_d       = 1'b0;
        sof_d         = 1'b0;
        eof_d         = 1'b0;
        frame_ok_d    = 1'b0;
        frame_err_d   = 1'b0;
        case (frame_state_q)
            FR_IDLE: begin
                if (link_up_s && word_sof_s) begin
                    frame_state_d = FR_PAYLOAD;
                    len_d         = data_i[15:8];
                    cnt_d         = 8'd0;
                    csum_d        = 16'h0000;
                end else begin
                    frame_state_d = FR_IDLE;
                end
            end
            FR_PAYLOAD: begin
                if (!link_up_s || link_drop_s) begin
                    frame_err_d   = 1'b1;
                    frame_state_d = FR_IDLE;
                end else if (word_data_s) begin
                    data_d  = data_i;
                    valid_d = 1'b1;
                    sof_d   = (cnt_q == 8'd0);
                    eof_d   = (cnt_q == len_q);
                    csum_d  = csum_q ^ data_i;
                    cnt_d   = cnt_q + 8'd1;
                    if (cnt_q == len_q) begin
`ifdef GTX_FRAME_RX_CHECKSUM_EN
                        frame_state_d = FR_CHECK;
`else
                        frame_ok_d    = 1'b1;
                        frame_state_d = FR_IDLE;
`endif
                    end else begin
                        frame_state_d = FR_PAYLOAD;
                    end
                end else if (word_sof_s) begin
                    // Abort the current frame and restart on this SOF.
                    frame_err_d   = 1'b1;
                    frame_state_d = FR_PAYLOAD;
                    len_d         = data_i[15:8];
                    cnt_d         = 8'd0;
                    csum_d        = 16'h0000;
                end else begin
                    frame_err_d   = 1'b1;
                    frame_state_d = FR_IDLE;
                end
            end
            FR_CHECK: begin
                if (!link_up_s || link_drop_s) begin
                    frame_err_d   = 1'b1;
                    frame_state_d = FR_IDLE;
                end else if (word_data_s) begin
                    if (data_i == csum_q) begin
                        frame_ok_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    frame_state_d = FR_IDLE;
                end else if (word_sof_s) begin
                    frame_err_d   = 1'b1;
                    frame_state_d = FR_PAYLOAD;
                    len_d         = data_i[15:8];
                    cnt_d         = 8'd0;
                    csum_d        = 16'h0000;
                end else begin
                    frame_err_d   = 1'b1;
                    frame_state_d = FR_IDLE;
                end
            end
            default: begin
                frame_state_d = FR_IDLE;
            end
        endcase
    end

    // Saturating error counter.
    always_comb begin
        if (frame_err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            link_state_q  <= LINK_DOWN;
            frame_state_q <= FR_IDLE;
            lock_cnt_q    <= 8'd0;
            bad_cnt_q     <= 4'd0;
            len_q         <= 8'd0;
            cnt_q         <= 8'd0;
            csum_q        <= 16'h0000;
            data_q        <= 16'h0000;
            valid_q       <= 1'b0;
            sof_q         <= 1'b0;
            eof_q         <= 1'b0;
            frame_ok_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            err_cnt_q     <= 16'h0000;
        end else begin
            link_state_q  <= link_state_d;
            frame_state_q <= frame_state_d;
            lock_cnt_q    <= lock_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            csum_q        <= csum_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            sof_q         <= sof_d;
            eof_q         <= eof_d;
            frame_ok_q    <= frame_ok_d;
            frame_err_q   <= frame_err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign sof_o       = sof_q;
    assign eof_o       = eof_q;
    assign frame_ok_o  = frame_ok_q;
    assign frame_err_o = frame_err_q;
    assign link_up_o   = (link_state_q == LINK_UP);
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_gtx_frame_rx.sv
// Scoreboard bench for gtx_frame_rx: directed words push expected output events, a negedge monitor compares.
module tb_gtx_frame_rx;

`ifdef GTX_FRAME_RX_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ctrl;
    logic [15:0] data;
    logic [15:0] data_o;
    logic        valid_o, sof_o, eof_o, frame_ok_o, frame_err_o, link_up_o;
    logic [15:0] err_cnt_o;

    always #5 clk = ~clk;

    gtx_frame_rx #(.LOCK_CNT(16), .UNLOCK_CNT(4)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .ctrl_i      (ctrl),
        .data_i      (data),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .sof_o       (sof_o),
        .eof_o       (eof_o),
        .frame_ok_o  (frame_ok_o),
        .frame_err_o (frame_err_o),
        .link_up_o   (link_up_o),
        .err_cnt_o   (err_cnt_o)
    );

    typedef struct packed {
        logic        valid;
        logic [15:0] data;
        logic        sof;
        logic        eof;
        logic        ok;
        logic        err;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  mon_e;
    int   tests = 0;
    int   fails = 0;
    int   exp_err = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    // Monitor: every cycle with an output event pops one expected event.
    always @(negedge clk) begin
        if (valid_o || frame_ok_o || frame_err_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output",
                      {11'd0, valid_o, sof_o, eof_o, frame_ok_o, frame_err_o, data_o}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_flags", {27'd0, valid_o, sof_o, eof_o, frame_ok_o, frame_err_o},
                      {27'd0, mon_e.valid, mon_e.sof, mon_e.eof, mon_e.ok, mon_e.err});
                if (mon_e.valid) begin
                    check("out_data", {16'd0, data_o}, {16'd0, mon_e.data});
                end
            end
        end
    end

    task automatic put(input logic [1:0] c, input logic [15:0] d);
        ctrl = c;
        data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_words(input int n);
        for (int i = 0; i < n; i++) put(2'b01, 16'h50BC);
    endtask

    task automatic sof(input logic [7:0] len);
        put(2'b01, {len, 8'hFB});
    endtask

    task automatic dw(input logic [15:0] d);
        put(2'b00, d);
    endtask

    task automatic exp_w(input logic [15:0] d, input logic s, input logic e, input logic o);
        exp_q.push_back('{1'b1, d, s, e, o, 1'b0});
    endtask

    task automatic exp_f(input logic o, input logic e);
        exp_q.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, o, e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] x;
        logic [15:0] d;
        logic [7:0]  b;

        rst_n = 1'b0;
        ctrl  = 2'b00;
        data  = 16'h0000;
        @(posedge clk);
        #1;
        put(2'b01, 16'h50BC);
        check("reset_outputs",
              {10'd0, valid_o, sof_o, eof_o, frame_ok_o, frame_err_o, link_up_o, data_o}, 32'd0);
        check("reset_err_cnt", {16'd0, err_cnt_o}, 32'd0);
        rst_n = 1'b1;

        idle_words(15);
        dw(16'h0001);
        check("no_lock_15_then_data", {31'd0, link_up_o}, 32'd0);
        idle_words(15);
        check("link_before_16th", {31'd0, link_up_o}, 32'd0);
        idle_words(1);
        check("link_after_16th", {31'd0, link_up_o}, 32'd1);

        // Three-word frame with correct checksum 1234^00FF^5678.
        sof(8'h02);
        exp_w(16'h1234, 1'b1, 1'b0, 1'b0); dw(16'h1234);
        exp_w(16'h00FF, 1'b0, 1'b0, 1'b0); dw(16'h00FF);
        exp_w(16'h5678, 1'b0, 1'b1, !CSUM); dw(16'h5678);
        if (CSUM) exp_f(1'b1, 1'b0);
        dw(16'h44B3);
        idle_words(2);
        check("err_cnt_after_good", {16'd0, err_cnt_o}, 32'(exp_err));

        // Same frame with a wrong checksum.
        sof(8'h02);
        exp_w(16'h1234, 1'b1, 1'b0, 1'b0); dw(16'h1234);
        exp_w(16'h00FF, 1'b0, 1'b0, 1'b0); dw(16'h00FF);
        exp_w(16'h5678, 1'b0, 1'b1, !CSUM); dw(16'h5678);
        if (CSUM) begin
            exp_f(1'b0, 1'b1);
            exp_err++;
        end
        dw(16'h0000);
        idle_words(2);
        check("err_cnt_after_bad_csum", {16'd0, err_cnt_o}, 32'(exp_err));

        // SOF mid-payload aborts and restarts with a one-word frame.
        sof(8'h03);
        exp_w(16'h1111, 1'b1, 1'b0, 1'b0); dw(16'h1111);
        exp_w(16'h2222, 1'b0, 1'b0, 1'b0); dw(16'h2222);
        exp_f(1'b0, 1'b1);
        exp_err++;
        sof(8'h00);
        exp_w(16'hABCD, 1'b1, 1'b1, !CSUM); dw(16'hABCD);
        if (CSUM) exp_f(1'b1, 1'b0);
        dw(16'hABCD);
        idle_words(2);
        check("err_cnt_after_sof_abort", {16'd0, err_cnt_o}, 32'(exp_err));

        // DATA words outside a frame are dropped silently.
        dw(16'hDEAD);
        dw(16'hBEEF);
        idle_words(1);
        check("data_in_idle_no_err", {16'd0, err_cnt_o}, 32'(exp_err));

        // Maximum length frame (256 words).
        sof(8'hFF);
        x = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            d = {b, ~b};
            exp_w(d, (i == 0), (i == 255), (i == 255) && !CSUM);
            x = x ^ d;
            dw(d);
        end
        if (CSUM) exp_f(1'b1, 1'b0);
        dw(x);
        idle_words(2);
        check("err_cnt_after_max_frame", {16'd0, err_cnt_o}, 32'(exp_err));

        // A legal word clears the consecutive-bad counter.
        put(2'b11, 16'h0000); put(2'b11, 16'h0000); put(2'b11, 16'h0000);
        idle_words(1);
        put(2'b11, 16'h0000); put(2'b11, 16'h0000); put(2'b11, 16'h0000);
        check("bad_cnt_cleared_by_legal", {31'd0, link_up_o}, 32'd1);
        idle_words(1);

        // Illegal words mid-payload: one abort, then link drops after four.
        sof(8'h07);
        exp_w(16'h0A0A, 1'b1, 1'b0, 1'b0); dw(16'h0A0A);
        exp_f(1'b0, 1'b1);
        exp_err++;
        put(2'b11, 16'h0000);
        check("link_after_1_bad", {31'd0, link_up_o}, 32'd1);
        put(2'b11, 16'h0000);
        put(2'b11, 16'h0000);
        check("link_after_3_bad", {31'd0, link_up_o}, 32'd1);
        put(2'b11, 16'h0000);
        check("link_down_after_4_bad", {31'd0, link_up_o}, 32'd0);
        dw(16'h0B0B);
        sof(8'h00);
        dw(16'h0C0C);
        idle_words(2);
        check("err_cnt_after_link_drop", {16'd0, err_cnt_o}, 32'(exp_err));

        idle_words(16);
        check("relock_after_16", {31'd0, link_up_o}, 32'd1);

        // Reset in the middle of a payload.
        sof(8'h03);
        exp_w(16'h7777, 1'b1, 1'b0, 1'b0); dw(16'h7777);
        rst_n = 1'b0;
        dw(16'h8888);
        check("reset_midframe_outputs",
              {10'd0, valid_o, sof_o, eof_o, frame_ok_o, frame_err_o, link_up_o, data_o}, 32'd0);
        check("reset_midframe_err_cnt", {16'd0, err_cnt_o}, 32'd0);
        rst_n = 1'b1;
        dw(16'h9999);
        idle_words(3);
        check("no_output_after_reset", {31'd0, link_up_o}, 32'd0);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
